// File: rtl/sd_card_cmd_responder.sv
// sd_card_cmd_responder: card-side SD CMD-line engine. Receives 48-bit host
// command frames on sd_clk rises, checks them, hands index/argument to local
// logic and transmits a 48-bit response on sd_clk falls after an NCR gap.
module sd_card_cmd_responder #(
  parameter int unsigned NCR = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        sd_clk_i,
  input  logic        sd_cmd_i,
  output logic        sd_cmd_o,
  output logic        sd_cmd_oe,
  output logic        cmd_valid_o,
  output logic        cmd_err_o,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  input  logic        rsp_valid_i,
  output logic        rsp_ready_o,
  input  logic [5:0]  rsp_index_i,
  input  logic [31:0] rsp_arg_i,
  input  logic        rsp_no_crc_i,
  output logic        busy_o
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned GAP_W  = 7;
  localparam int unsigned CRC_W  = 7;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned ARG_W  = 32;
  localparam int unsigned RXSR_W = IDX_W + ARG_W;
  localparam int unsigned TXSR_W = 2 + IDX_W + ARG_W;

  localparam logic [CNT_W-1:0] TX_BIT     = CNT_W'(1);
  localparam logic [CNT_W-1:0] FIRST_IDX  = CNT_W'(2);
  localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(39);
  localparam logic [CNT_W-1:0] LAST_CRC   = CNT_W'(46);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(47);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(NCR - 1);
  localparam logic [CRC_W-1:0] CRC_POLY   = CRC_W'(9);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RX   = 3'd1,
    ST_WAIT = 3'd2,
    ST_GAP  = 3'd3,
    ST_TX   = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic              sd_clk_q;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic              err_q, err_d;
  logic [RXSR_W-1:0] rx_sr_q, rx_sr_d;
  logic [TXSR_W-1:0] tx_sr_q, tx_sr_d;
  logic              no_crc_q, no_crc_d;

  logic              sd_cmd_d, sd_cmd_oe_d;
  logic              cmd_valid_d, cmd_err_d;
  logic [IDX_W-1:0]  cmd_index_d;
  logic [ARG_W-1:0]  cmd_arg_d;
  logic              rsp_ready_d, busy_d;

  logic              rise_c, fall_c, start_c, rx_err_c;
  logic [CNT_W-1:0]  tx_k_c;

  // One LFSR step of CRC7 (x^7 + x^3 + 1), MSB-first serial input
  function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] crc,
                                                 input logic             din);
    crc7_step = {crc[CRC_W-2:0], 1'b0} ^ ((crc[CRC_W-1] ^ din) ? CRC_POLY : '0);
  endfunction

  // SD clock edge strobes and frame-level conditions
  assign rise_c   = ~sd_clk_q & sd_clk_i;
  assign fall_c   = sd_clk_q & ~sd_clk_i;
  assign start_c  = rise_c & ~sd_cmd_i;
  assign rx_err_c = err_q | ~sd_cmd_i;
  assign tx_k_c   = bit_cnt_q + CNT_W'(1);

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a new host start bit in WAIT pre-empts acceptance
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_c) state_d = ST_RX;
      end
      ST_RX: begin
        if (rise_c && (bit_cnt_q == LAST_BIT)) begin
          state_d = rx_err_c ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (start_c) begin
          state_d = ST_RX;
        end else if (rsp_valid_i && rsp_ready_o) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (fall_c && (gap_cnt_q == GAP_LAST)) state_d = ST_TX;
      end
      ST_TX: begin
        if (fall_c && (bit_cnt_q == LAST_BIT)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    crc_d       = crc_q;
    err_d       = err_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    no_crc_d    = no_crc_q;
    sd_cmd_d    = sd_cmd_o;
    sd_cmd_oe_d = sd_cmd_oe;
    cmd_valid_d = 1'b0;
    cmd_err_d   = cmd_err_o;
    cmd_index_d = cmd_index_o;
    cmd_arg_d   = cmd_arg_o;
    rsp_ready_d = (state_d == ST_WAIT);
    busy_d      = (state_d != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        // Start bit seen: it contributes nothing to a zero-seeded CRC
        if (start_c) begin
          crc_d     = '0;
          bit_cnt_d = CNT_W'(1);
          err_d     = 1'b0;
        end
      end

      ST_RX: begin
        if (rise_c) begin
          if (bit_cnt_q == LAST_BIT) begin
            cmd_valid_d = 1'b1;
            cmd_err_d   = rx_err_c;
            cmd_index_d = rx_sr_q[RXSR_W-1:ARG_W];
            cmd_arg_d   = rx_sr_q[ARG_W-1:0];
            bit_cnt_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == TX_BIT) err_d = err_q | ~sd_cmd_i;
            if (bit_cnt_q <= LAST_DATA) begin
              crc_d = crc7_step(crc_q, sd_cmd_i);
            end else begin
              // CRC field: compare against the computed CRC, MSB first
              err_d = err_q | (sd_cmd_i ^ crc_q[CRC_W-1]);
              crc_d = {crc_q[CRC_W-2:0], 1'b0};
            end
            if ((bit_cnt_q >= FIRST_IDX) && (bit_cnt_q <= LAST_DATA)) begin
              rx_sr_d = {rx_sr_q[RXSR_W-2:0], sd_cmd_i};
            end
          end
        end
      end

      ST_WAIT: begin
        if (start_c) begin
          crc_d     = '0;
          bit_cnt_d = CNT_W'(1);
          err_d     = 1'b0;
        end else if (rsp_valid_i && rsp_ready_o) begin
          tx_sr_d   = {2'b00, rsp_index_i, rsp_arg_i};
          no_crc_d  = rsp_no_crc_i;
          crc_d     = '0;
          gap_cnt_d = '0;
        end
      end

      ST_GAP: begin
        if (fall_c) begin
          if (gap_cnt_q == GAP_LAST) begin
            sd_cmd_d    = tx_sr_q[TXSR_W-1];
            sd_cmd_oe_d = 1'b1;
            tx_sr_d     = {tx_sr_q[TXSR_W-2:0], 1'b0};
            crc_d       = crc7_step(crc_q, tx_sr_q[TXSR_W-1]);
            bit_cnt_d   = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end

      ST_TX: begin
        if (fall_c) begin
          if (bit_cnt_q == LAST_BIT) begin
            sd_cmd_d    = 1'b1;
            sd_cmd_oe_d = 1'b0;
            bit_cnt_d   = '0;
          end else begin
            bit_cnt_d = tx_k_c;
            if (tx_k_c <= LAST_DATA) begin
              sd_cmd_d = tx_sr_q[TXSR_W-1];
              tx_sr_d  = {tx_sr_q[TXSR_W-2:0], 1'b0};
              crc_d    = crc7_step(crc_q, tx_sr_q[TXSR_W-1]);
            end else if (tx_k_c <= LAST_CRC) begin
              sd_cmd_d = no_crc_q | crc_q[CRC_W-1];
              crc_d    = {crc_q[CRC_W-2:0], 1'b0};
            end else begin
              sd_cmd_d = 1'b1;
            end
          end
        end
      end

      default: begin
        sd_cmd_d    = 1'b1;
        sd_cmd_oe_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset also discards any latched response
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sd_clk_q    <= 1'b0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      crc_q       <= '0;
      err_q       <= 1'b0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      no_crc_q    <= 1'b0;
      sd_cmd_o    <= 1'b1;
      sd_cmd_oe   <= 1'b0;
      cmd_valid_o <= 1'b0;
      cmd_err_o   <= 1'b0;
      cmd_index_o <= '0;
      cmd_arg_o   <= '0;
      rsp_ready_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      sd_clk_q    <= sd_clk_i;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      crc_q       <= crc_d;
      err_q       <= err_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      no_crc_q    <= no_crc_d;
      sd_cmd_o    <= sd_cmd_d;
      sd_cmd_oe   <= sd_cmd_oe_d;
      cmd_valid_o <= cmd_valid_d;
      cmd_err_o   <= cmd_err_d;
      cmd_index_o <= cmd_index_d;
      cmd_arg_o   <= cmd_arg_d;
      rsp_ready_o <= rsp_ready_d;
      busy_o      <= busy_d;
    end
  end

endmodule
